c1541_gcr_track_loader: RTL

//  Moves whole half-track GCR images between SD card and c1541_direct_gcr track buffer.

---
 rtl/c1541_gcr_track_loader_pkg.sv | 21 ++
 rtl/c1541_gcr_track_loader_if.sv | 13 +
 rtl/c1541_gcr_track_loader_sd_req.sv | 48 ++++
 rtl/c1541_gcr_track_loader.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/c1541_gcr_track_loader_pkg.sv
// Shared types and constants for the half-track GCR loader.
package c1541_gcr_track_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FLUSH_REQ,
    ST_FLUSH_ACK,
    ST_LOAD_REQ,
    ST_LOAD_ACK
  } loader_state_t;

  localparam int         BLK_PER_TRK_DEF = 16;
  localparam logic [6:0] TRK_INVALID     = 7'h7F;

  function automatic logic is_xfer(input loader_state_t s);
    return (s == ST_FLUSH_REQ) || (s == ST_FLUSH_ACK) ||
           (s == ST_LOAD_REQ)  || (s == ST_LOAD_ACK);
  endfunction

endpackage

// File: rtl/c1541_gcr_track_loader_if.sv
// SD block-transfer port between the track loader (master) and the SD host (slave).
interface c1541_gcr_track_loader_if #(
  parameter int LBA_W = 32
) ();
  logic [LBA_W-1:0] sd_lba;
  logic [5:0]       sd_blk_cnt;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (output sd_lba, sd_blk_cnt, sd_rd, sd_wr, input sd_ack);
  modport slave  (input sd_lba, sd_blk_cnt, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/c1541_gcr_track_loader_sd_req.sv
// Generic SD req/ack handshake: request held until ack rises, done pulses on ack fall.
module c1541_sd_req #(
  parameter int LBA_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_write,
  input  logic [LBA_W-1:0] lba,
  input  logic             sd_ack,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [LBA_W-1:0] sd_lba,
  output logic             granted,
  output logic             done
);
  logic ack_q;
  logic active;

  assign granted = (sd_rd | sd_wr) & sd_ack & ~ack_q;
  // active keeps a stray ack fall (e.g. right after reset) from looking like completion
  assign done    = active & ~(sd_rd | sd_wr) & ack_q & ~sd_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      active <= 1'b0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      sd_lba <= '0;
    end else begin
      ack_q <= sd_ack;
      if (start) begin
        active <= 1'b1;
        sd_rd  <= ~is_write;
        sd_wr  <= is_write;
        sd_lba <= lba;
      end else begin
        if (granted) begin
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
        end
        if (done) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/c1541_gcr_track_loader.sv
// Moves whole half-track GCR images between SD and the track buffer; flushes dirty
// tracks on head move or motor-off, then loads the settled track, holding busy meanwhile.
module c1541_gcr_track_loader
  import c1541_gcr_track_loader_pkg::*;
#(
  parameter int BLK_PER_TRK = BLK_PER_TRK_DEF,
  parameter int SETTLE_CLKS = 48000,
  parameter int LBA_W       = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic [6:0] track,
  input  logic       mtr,
  input  logic       gcr_we,
  c1541_gcr_track_loader_if.master sd,
  output logic       busy,
  output logic       loaded
);
  localparam int               CNT_W    = $clog2(SETTLE_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CLKS - 1);

  loader_state_t    state, state_nxt;
  logic [6:0]       cur_trk, req_trk;
  logic             dirty, mount_pend, mtr_q;
  logic [CNT_W-1:0] settle_cnt;
  logic [5:0]       blk_cnt;
  logic             start, is_write, granted, done, xfer_nxt, ack_done, mount_any;
  logic [LBA_W-1:0] start_lba;

  function automatic logic [LBA_W-1:0] trk_lba(input logic [6:0] t);
    return LBA_W'(t) * LBA_W'(BLK_PER_TRK);
  endfunction

  assign mount_any = mount_pend | img_mounted;
  assign ack_done  = done & ((state == ST_FLUSH_ACK) | (state == ST_LOAD_ACK));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (img_mounted || track != cur_trk) state_nxt = ST_SETTLE;
        else if (mtr_q && !mtr && dirty)     state_nxt = ST_FLUSH_REQ;
      end
      ST_SETTLE: begin
        // a mount arriving now discards the dirty data rather than writing it to the new image
        if (track == req_trk && ce && settle_cnt == CNT_LAST)
          state_nxt = (dirty && !img_mounted) ? ST_FLUSH_REQ : ST_LOAD_REQ;
      end
      ST_FLUSH_REQ: if (granted) state_nxt = ST_FLUSH_ACK;
      ST_FLUSH_ACK: begin
        if (done) state_nxt = (req_trk != cur_trk || mount_any) ? ST_LOAD_REQ : ST_IDLE;
      end
      ST_LOAD_REQ: if (granted) state_nxt = ST_LOAD_ACK;
      ST_LOAD_ACK: begin
        if (done) begin
          if (mount_any)              state_nxt = ST_LOAD_REQ;
          else if (track != req_trk)  state_nxt = ST_SETTLE;
          else                        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    xfer_nxt  = is_xfer(state_nxt);
    is_write  = (state_nxt == ST_FLUSH_REQ);
    start     = (state_nxt != state) &&
                ((state_nxt == ST_FLUSH_REQ) || (state_nxt == ST_LOAD_REQ));
    start_lba = is_write ? trk_lba(cur_trk) : trk_lba(req_trk);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_trk    <= TRK_INVALID;
      req_trk    <= TRK_INVALID;
      dirty      <= 1'b0;
      loaded     <= 1'b0;
      mount_pend <= 1'b0;
      mtr_q      <= 1'b0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      mtr_q   <= mtr;
      busy    <= xfer_nxt;
      blk_cnt <= xfer_nxt ? 6'(BLK_PER_TRK - 1) : 6'd0;

      if (state == ST_IDLE) req_trk <= track;
      if (state == ST_SETTLE) begin
        if (track != req_trk) begin
          req_trk    <= track;
          settle_cnt <= '0;
        end else if (ce && settle_cnt != CNT_LAST) begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end else begin
        settle_cnt <= '0;
      end

      if (state == ST_FLUSH_ACK && done)
        dirty <= 1'b0;
      else if (gcr_we && loaded && !img_readonly &&
               state != ST_FLUSH_REQ && state != ST_FLUSH_ACK)
        dirty <= 1'b1;

      if (state_nxt == ST_LOAD_REQ)
        loaded <= 1'b0;
      else if (state == ST_LOAD_ACK && done && !mount_any) begin
        loaded  <= 1'b1;
        cur_trk <= req_trk;
      end

      if (ack_done)                           mount_pend <= 1'b0;
      else if (img_mounted && is_xfer(state)) mount_pend <= 1'b1;

      if (img_mounted && !is_xfer(state)) begin
        dirty  <= 1'b0;
        loaded <= 1'b0;
      end
    end
  end

  c1541_sd_req #(.LBA_W(LBA_W)) u_sd_req (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .is_write (is_write),
    .lba      (start_lba),
    .sd_ack   (sd.sd_ack),
    .sd_rd    (sd.sd_rd),
    .sd_wr    (sd.sd_wr),
    .sd_lba   (sd.sd_lba),
    .granted  (granted),
    .done     (done)
  );

  assign sd.sd_blk_cnt = blk_cnt;

endmodule
